// File: rtl/piano_pkg.sv
// Shared types and tables for the piano note sequencer.
// Holds the state encoding, ROM entry layout and divisor table.
package piano_pkg;

    localparam int NOTE_W = 4;
    localparam int BEAT_W = 4;
    localparam int ROM_AW = 4;
    localparam int HP_TW  = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP,
        ST_LIVE
    } state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [BEAT_W-1:0] beats;
    } entry_t;

    function automatic logic [HP_TW-1:0] hp_of(input logic [NOTE_W-1:0] n);
        case (n)
            4'd1:    hp_of = 17'd95556;
            4'd2:    hp_of = 17'd85131;
            4'd3:    hp_of = 17'd75843;
            4'd4:    hp_of = 17'd71586;
            4'd5:    hp_of = 17'd63776;
            4'd6:    hp_of = 17'd56818;
            4'd7:    hp_of = 17'd50619;
            4'd8:    hp_of = 17'd47778;
            default: hp_of = '0;
        endcase
    endfunction

    // Lowest set key wins, so scan downwards and keep the last hit.
    function automatic logic [NOTE_W-1:0] key_note(input logic [7:0] k);
        key_note = '0;
        for (int i = 7; i >= 0; i--) begin
            if (k[i]) key_note = NOTE_W'(i + 1);
        end
    endfunction

endpackage

// File: rtl/piano_song_rom.sv
// Auto-play melody table: {note, beats} per address.
// beats == 0 marks the end of the song.
module piano_song_rom
    import piano_pkg::*;
(
    input  logic [ROM_AW-1:0] addr,
    output entry_t            entry
);

    always_comb begin
        case (addr)
            4'd0:    entry = '{note: 4'd1, beats: 4'd2};
            4'd1:    entry = '{note: 4'd0, beats: 4'd1};
            4'd2:    entry = '{note: 4'd6, beats: 4'd1};
            default: entry = '{note: 4'd0, beats: 4'd0};
        endcase
    end

endmodule

// File: rtl/piano_note_sequencer.sv
// Arbitrates live keys against the melody ROM and drives the
// tone generator divisor/enable; keys pause and resume the song.
module piano_note_sequencer
    import piano_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int HP_W     = 17,
    parameter bit LOOP     = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PLAY,
    input  logic              STOP,
    input  logic [7:0]        KEY,
    output logic [HP_W-1:0]   HALF_PERIOD,
    output logic              TONE_EN,
    output logic [NOTE_W-1:0] NOTE_IDX,
    output logic              BUSY
);

    localparam int PW = $clog2(TICK_DIV + 1);

    state_t            state, saved, n_state, live_saved;
    logic [ROM_AW-1:0] addr, n_addr, rom_addr;
    logic [PW-1:0]     presc, n_presc;
    logic [BEAT_W-1:0] beat_cnt, n_beat;
    logic [NOTE_W-1:0] cur_note, n_note;
    logic              tick;
    entry_t            entry, entry0;

    assign rom_addr = (state == ST_GAP) ? addr + 4'd1 : addr;
    assign tick     = (presc == PW'(TICK_DIV - 1));

    piano_song_rom u_rom (.addr(rom_addr), .entry(entry));
    piano_song_rom u_rom0 (.addr('0), .entry(entry0));

    // Melody step as if no key were pressed.
    always_comb begin
        n_state = state;
        n_addr  = addr;
        n_presc = presc;
        n_beat  = beat_cnt;
        n_note  = cur_note;
        case (state)
            ST_IDLE: begin
                n_addr = '0;
                if (PLAY && !STOP && KEY == '0 && entry.beats != '0) begin
                    n_state = ST_PLAY;
                    n_presc = '0;
                    n_beat  = entry.beats;
                    n_note  = entry.note;
                end
            end
            ST_PLAY: begin
                if (STOP) begin
                    n_state = ST_IDLE;
                    n_addr  = '0;
                    n_presc = '0;
                end else begin
                    n_presc = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        n_beat = beat_cnt - 1'b1;
                        if (beat_cnt == 4'd1) n_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (STOP) begin
                    n_state = ST_IDLE;
                    n_addr  = '0;
                    n_presc = '0;
                end else begin
                    n_presc = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (entry.beats != '0) begin
                            n_state = ST_PLAY;
                            n_addr  = rom_addr;
                            n_beat  = entry.beats;
                            n_note  = entry.note;
                        end else if (LOOP && entry0.beats != '0) begin
                            n_state = ST_PLAY;
                            n_addr  = '0;
                            n_beat  = entry0.beats;
                            n_note  = entry0.note;
                        end else begin
                            n_state = ST_IDLE;
                            n_addr  = '0;
                        end
                    end
                end
            end
            default: begin
                n_state = STOP ? ST_IDLE : saved;
                if (n_state == ST_IDLE) n_addr = '0;
            end
        endcase
    end

    assign live_saved = (state != ST_LIVE) ? n_state :
                        (STOP ? ST_IDLE : saved);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            saved       <= ST_IDLE;
            addr        <= '0;
            presc       <= '0;
            beat_cnt    <= '0;
            cur_note    <= '0;
            HALF_PERIOD <= '0;
            TONE_EN     <= 1'b0;
            NOTE_IDX    <= '0;
            BUSY        <= 1'b0;
        end else if (KEY != '0) begin
            state <= ST_LIVE;
            saved <= live_saved;
            if (state != ST_LIVE) begin
                addr     <= n_addr;
                presc    <= n_presc;
                beat_cnt <= n_beat;
                cur_note <= n_note;
            end else if (STOP) begin
                addr <= '0;
            end
            NOTE_IDX    <= key_note(KEY);
            TONE_EN     <= 1'b1;
            HALF_PERIOD <= HP_W'(hp_of(key_note(KEY)));
            BUSY        <= (live_saved != ST_IDLE);
        end else begin
            state       <= n_state;
            addr        <= n_addr;
            presc       <= n_presc;
            beat_cnt    <= n_beat;
            cur_note    <= n_note;
            NOTE_IDX    <= (n_state == ST_PLAY) ? n_note : '0;
            TONE_EN     <= (n_state == ST_PLAY) && (n_note != '0);
            HALF_PERIOD <= HP_W'(hp_of((n_state == ST_PLAY) ? n_note : '0));
            BUSY        <= (n_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_piano_note_sequencer.sv
// Directed bench for the piano note sequencer.
// Two instances: one-shot song and looping song.
module tb_piano_note_sequencer;

    logic        CLK;
    logic        RESET;
    logic        PLAY, STOP;
    logic [7:0]  KEY;
    logic [16:0] HALF_PERIOD;
    logic        TONE_EN;
    logic [3:0]  NOTE_IDX;
    logic        BUSY;

    logic        l_play;
    logic [16:0] l_hp;
    logic        l_tone;
    logic [3:0]  l_note;
    logic        l_busy;

    int checks = 0;
    int passed = 0;

    piano_note_sequencer #(.TICK_DIV(4), .HP_W(17), .LOOP(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .PLAY(PLAY), .STOP(STOP), .KEY(KEY),
        .HALF_PERIOD(HALF_PERIOD), .TONE_EN(TONE_EN),
        .NOTE_IDX(NOTE_IDX), .BUSY(BUSY)
    );

    piano_note_sequencer #(.TICK_DIV(4), .HP_W(17), .LOOP(1'b1)) dut_loop (
        .CLK(CLK), .RESET(RESET), .PLAY(l_play), .STOP(1'b0), .KEY(8'd0),
        .HALF_PERIOD(l_hp), .TONE_EN(l_tone),
        .NOTE_IDX(l_note), .BUSY(l_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [16:0] exp_hp(input int n);
        case (n)
            1:       exp_hp = 17'd95556;
            3:       exp_hp = 17'd75843;
            6:       exp_hp = 17'd56818;
            default: exp_hp = 17'd0;
        endcase
    endfunction

    task automatic test_reset();
        logic [22:0] obs;
        RESET = 1'b0;
        repeat (3) step();
        RESET = 1'b1;
        for (int i = 0; i < 50; i++) begin
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== 23'd0)
                $display("FAIL reset_idle cyc %0d got %h want 0", i, obs);
            else passed++;
            step();
        end
    endtask

    task automatic test_song();
        logic [22:0] obs, exp;
        int n;
        logic b;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        for (int i = 0; i <= 28; i++) begin
            n = (i < 8) ? 1 : (i >= 20 && i < 24) ? 6 : 0;
            b = (i < 28);
            exp = {4'(n), n != 0, exp_hp(n), b};
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== exp)
                $display("FAIL song cyc %0d got %h want %h", i, obs, exp);
            else passed++;
            step();
        end
    endtask

    task automatic test_live_key();
        logic [22:0] obs, exp;
        int c1 = 0;
        int t;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (NOTE_IDX == 4'd1 && TONE_EN) c1++;
            if (i == 3) KEY = 8'b0010_0100;
            step();
        end
        exp = {4'd3, 1'b1, 17'd75843, 1'b1};
        for (int i = 0; i < 10; i++) begin
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== exp)
                $display("FAIL live_key cyc %0d got %h want %h", i, obs, exp);
            else passed++;
            if (i == 9) KEY = 8'd0;
            step();
        end
        for (int i = 0; i < 20; i++) begin
            if (NOTE_IDX == 4'd1 && TONE_EN) c1++;
            step();
        end
        checks++;
        if (c1 !== 8)
            $display("FAIL live_resume c4 cycles got %0d want 8", c1);
        else passed++;
        t = 0;
        while (BUSY && t < 100) begin
            step();
            t++;
        end
        checks++;
        if (BUSY !== 1'b0)
            $display("FAIL live_song_end busy got %b want 0", BUSY);
        else passed++;
    endtask

    task automatic test_stop();
        logic [22:0] obs;
        PLAY = 1'b1;
        STOP = 1'b1;
        step();
        PLAY = 1'b0;
        STOP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== 23'd0)
                $display("FAIL stop_with_play cyc %0d got %h want 0", i, obs);
            else passed++;
            step();
        end
        KEY = 8'b0000_0001;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        KEY = 8'd0;
        step();
        obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
        checks++;
        if (obs !== 23'd0)
            $display("FAIL play_with_key got %h want 0", obs);
        else passed++;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        repeat (9) step();
        obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
        checks++;
        if (obs !== 23'd1)
            $display("FAIL gap_state got %h want 000001", obs);
        else passed++;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        for (int i = 0; i < 12; i++) begin
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== 23'd0)
                $display("FAIL stop_in_gap cyc %0d got %h want 0", i, obs);
            else passed++;
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] obs, exp;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        step();
        exp = {4'd1, 1'b1, 17'd95556, 1'b1};
        obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
        checks++;
        if (obs !== exp)
            $display("FAIL pre_reset_note got %h want %h", obs, exp);
        else passed++;
        RESET = 1'b0;
        #2;
        obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
        checks++;
        if (obs !== 23'd0)
            $display("FAIL async_reset got %h want 0", obs);
        else passed++;
        step();
        RESET = 1'b1;
        repeat (3) step();
        obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
        checks++;
        if (obs !== 23'd0)
            $display("FAIL post_reset_idle got %h want 0", obs);
        else passed++;
        PLAY = 1'b1;
        step();
        PLAY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp = (i < 8) ? {4'd1, 1'b1, 17'd95556, 1'b1} : 23'd1;
            obs = {NOTE_IDX, TONE_EN, HALF_PERIOD, BUSY};
            checks++;
            if (obs !== exp)
                $display("FAIL restart cyc %0d got %h want %h", i, obs, exp);
            else passed++;
            step();
        end
    endtask

    task automatic test_loop();
        l_play = 1'b1;
        step();
        l_play = 1'b0;
        for (int i = 0; i <= 28; i++) begin
            checks++;
            if (l_busy !== 1'b1)
                $display("FAIL loop_busy cyc %0d got %b want 1", i, l_busy);
            else passed++;
            if (i == 27) begin
                checks++;
                if (l_note !== 4'd0)
                    $display("FAIL loop_gap got %0d want 0", l_note);
                else passed++;
            end
            if (i == 28) begin
                checks++;
                if ({l_note, l_tone, l_hp} !== {4'd1, 1'b1, 17'd95556})
                    $display("FAIL loop_restart got %0d/%b/%0d want 1/1/95556",
                             l_note, l_tone, l_hp);
                else passed++;
            end
            step();
        end
    endtask

    initial begin
        PLAY   = 1'b0;
        STOP   = 1'b0;
        KEY    = 8'd0;
        l_play = 1'b0;
        RESET  = 1'b0;
        test_reset();
        test_song();
        test_live_key();
        test_stop();
        test_async_reset();
        test_loop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
